// File: rtl/coin_pkg.sv
// Coin hopper shared definitions: FSM encoding and denominations.
// Shared by the change dispenser and the vending controller.
package coin_pkg;

  localparam int UNIT_CENTS     = 5;
  localparam int DENOM_5_UNITS  = 1;
  localparam int DENOM_10_UNITS = 2;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  typedef enum logic {
    DENOM_5,
    DENOM_10
  } denom_t;

  function automatic int unsigned denom_units(denom_t d);
    return (d == DENOM_10) ? DENOM_10_UNITS : DENOM_5_UNITS;
  endfunction

endpackage

// File: rtl/coin_change_dispenser_if.sv
// Change-request handshake between vending controller and dispenser.
// A request transfers on a cycle with req_valid && req_ready.
interface coin_change_dispenser_if #(
  parameter int AMT_W = 6
);

  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_units;

  modport master (
    output req_valid,
    output req_units,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_units,
    output req_ready
  );

endinterface

// File: rtl/coin_ack_timer.sv
// Hopper acknowledge watchdog: restarted by each eject pulse,
// strobes timeout once ACK_TIMEOUT cycles have elapsed since it.
module coin_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // the eject cycle itself is the first elapsed cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CW'(1);
    end else if (run) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = run && (cnt == CW'(ACK_TIMEOUT - 1));

endmodule

// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: pays a request with 10/5 coins, one eject at a time.
// Define CHANGE_FALLBACK_EN to pay with 5 coins when the 10 tube is empty.
module coin_change_dispenser
  import coin_pkg::*;
#(
  parameter int AMT_W       = 6,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  coin_change_dispenser_if.slave  req,
  output logic                    eject_5,
  output logic                    eject_10,
  input  logic                    hopper_ack,
  input  logic                    hopper_empty_5,
  input  logic                    hopper_empty_10,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [AMT_W-1:0]        paid_units
);

  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t           state;
  denom_t           denom;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] step;
  logic [RW-1:0]    retry;
  logic             timeout;
  logic             rem_zero;
  logic             rem_big;
  logic             rem_one;
  logic             pick10;
  logic             pick5;

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  assign step     = AMT_W'(denom_units(denom));
  assign rem_zero = (rem == '0);
  assign rem_big  = (rem >= AMT_W'(DENOM_10_UNITS));
  assign rem_one  = (rem == AMT_W'(DENOM_5_UNITS));
  assign pick10   = rem_big && !hopper_empty_10;

`ifdef CHANGE_FALLBACK_EN
  assign pick5 = (rem_one || (rem_big && hopper_empty_10))
              && !hopper_empty_5;
`else
  assign pick5 = rem_one && !hopper_empty_5;
`endif

  coin_ack_timer #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == EJECT),
    .run     (state == WAIT_ACK),
    .timeout (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      denom      <= DENOM_5;
      rem        <= '0;
      retry      <= '0;
      eject_5    <= 1'b0;
      eject_10   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      paid_units <= '0;
    end else begin
      eject_5  <= 1'b0;
      eject_10 <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req.req_valid) begin
            rem        <= req.req_units;
            paid_units <= '0;
            error      <= 1'b0;
            retry      <= '0;
            state      <= SELECT;
          end
        end
        SELECT: begin
          unique case (1'b1)
            rem_zero: begin
              done  <= 1'b1;
              state <= DONE;
            end
            pick10: begin
              denom    <= DENOM_10;
              eject_10 <= 1'b1;
              state    <= EJECT;
            end
            pick5: begin
              denom   <= DENOM_5;
              eject_5 <= 1'b1;
              state   <= EJECT;
            end
            default: begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FAULT;
            end
          endcase
        end
        EJECT: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // an ack landing on the timeout cycle still counts
          if (hopper_ack) begin
            rem        <= rem - step;
            paid_units <= paid_units + step;
            retry      <= '0;
            state      <= SELECT;
          end else if (timeout) begin
            if (retry < RW'(MAX_RETRY)) begin
              retry    <= retry + RW'(1);
              eject_5  <= (denom == DENOM_5);
              eject_10 <= (denom == DENOM_10);
              state    <= EJECT;
            end else begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= FAULT;
            end
          end
        end
        DONE, FAULT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
